conv_scheduler: RTL and testbench

Sequencing controller for the single-kernel convolution engine. Runs one input feature map through NUM_FILTERS filters in turn. For each filter it fetches the kernel weights from a weight memory, restarts the engine, enables it until the engine reports done, then hands the finished output map downstream with a valid/ready handshake. It sits between the layer-level control and the convolution engine / output buffer.

---
 rtl/conv_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_conv_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// Per-filter sequencer for the convolution engine: fetch kernel, clear and run the engine, hand off the map.
// Optional RUN watchdog (err output) is built only when CONV_SCHED_TIMEOUT_EN is defined.
module conv_scheduler #(
  parameter int NUM_FILTERS    = 4,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int WADDR_WIDTH    = $clog2(NUM_FILTERS * KERNEL_SIZE * KERNEL_SIZE),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         w_rd_en,
  output logic [WADDR_WIDTH-1:0]       w_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] w_rd_data,
  output logic signed [DATA_WIDTH-1:0] weights [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         conv_clear,
  output logic                         conv_en,
  input  logic                         conv_done,
  output logic                         ofmap_valid,
  input  logic                         ofmap_ready,
  output logic [(NUM_FILTERS > 1 ? $clog2(NUM_FILTERS) : 1)-1:0] ofmap_filter
);

  localparam int K2 = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KW = $clog2(K2 + 1);
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [KW-1:0]          K_LAST = KW'(K2);
  localparam logic [FW-1:0]          F_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [WADDR_WIDTH-1:0] K2_A   = WADDR_WIDTH'(K2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_OUT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [FW-1:0] filt;
  logic [KW-1:0] kidx;
  logic          run_expired;

  logic          rd_vld_p0;
  logic          cap_vld_p1;
  logic [KW-1:0] cap_idx_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (kidx == K_LAST) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (conv_done) begin
          state_nxt = S_OUT;
        end else if (run_expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        if (ofmap_ready) state_nxt = (filt == F_LAST) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // kidx walks 0..K2 across LOAD: reads on 0..K2-1, final capture on K2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      kidx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            filt <= '0;
            kidx <= '0;
          end
        end
        S_LOAD: begin
          kidx <= (kidx == K_LAST) ? '0 : kidx + KW'(1);
        end
        S_OUT: begin
          if (ofmap_ready && (filt != F_LAST)) filt <= filt + FW'(1);
        end
        default: ;
      endcase
    end
  end

  // Stage p0: read issue; address = f*K2 + k, unsigned at WADDR_WIDTH.
  assign rd_vld_p0 = (state == S_LOAD) && (kidx != K_LAST);
  assign w_rd_en   = rd_vld_p0;
  assign w_rd_addr = rd_vld_p0 ? (WADDR_WIDTH'(filt) * K2_A + WADDR_WIDTH'(kidx)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= rd_vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    cap_idx_p1 <= kidx;
  end

  // Stage p1: memory data is valid one cycle after the read; store row-major.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          weights[r][c] <= '0;
        end
      end
    end else if (cap_vld_p1) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          if (cap_idx_p1 == KW'(r * KERNEL_SIZE + c)) weights[r][c] <= w_rd_data;
        end
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign conv_clear   = (state == S_CLEAR);
  assign conv_en      = (state == S_RUN);
  assign ofmap_valid  = (state == S_OUT);
  assign ofmap_filter = filt;

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] run_cnt;

  // Counter idles at zero so every RUN entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      err     <= 1'b0;
    end else begin
      run_cnt <= (state == S_RUN) ? run_cnt + TW'(1) : '0;
      if ((state == S_RUN) && !conv_done && run_expired) begin
        err <= 1'b1;
      end else if ((state == S_IDLE) && start) begin
        err <= 1'b0;
      end
    end
  end

  assign run_expired = (run_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign run_expired    = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
// Randomized bench for conv_scheduler: a per-cycle expected timeline is built from the
// filter/phase arithmetic (LOAD K2+1, CLEAR 1, RUN R, OUT H, DONE 1) and compared every cycle.
module tb_conv_scheduler;

  localparam int NF = 2;
  localparam int K  = 3;
  localparam int K2 = K * K;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic signed [DW-1:0] w_rd_data = '0;
  logic signed [DW-1:0] weights [K][K];
  logic                 conv_clear;
  logic                 conv_en;
  logic                 conv_done;
  logic                 ofmap_valid;
  logic                 ofmap_ready;
  logic [0:0]           ofmap_filter;

  always #5 clk = ~clk;

  conv_scheduler #(
    .NUM_FILTERS   (NF),
    .KERNEL_SIZE   (K),
    .DATA_WIDTH    (DW),
    .WADDR_WIDTH   (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .weights     (weights),
    .conv_clear  (conv_clear),
    .conv_en     (conv_en),
    .conv_done   (conv_done),
    .ofmap_valid (ofmap_valid),
    .ofmap_ready (ofmap_ready),
    .ofmap_filter(ofmap_filter)
  );

  // Weight memory: mem[a] = a - 9, one-cycle read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= DW'(int'(w_rd_addr) - 9);
  end

  // One entry per clock: inputs to drive and outputs required.
  typedef struct {
    bit rst, st, cd, rdy;
    bit busy, rd, clr, en, vld, dn, er;
    int addr, filt, wmode, wf;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  bit   active = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  bit cd_lvl    = 1'b0;
  bit err_lvl   = 1'b0;
  int wmode_lvl = 2;
  int wf_lvl    = 0;
  int rr[NF];
  int hh[NF];

  int done_cnt = 0;
  int addr_log[$];
  bit snap_taken = 1'b0;
  int snap[K];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic ent_t base_e();
    ent_t e;
    e       = '{default: 0};
    e.cd    = cd_lvl;
    e.er    = err_lvl;
    e.wmode = wmode_lvl;
    e.wf    = wf_lvl;
    return e;
  endfunction

  task automatic junkify(inout ent_t e, input bit junk, input bit keep_rdy);
    if (junk) begin
      e.st = ($urandom_range(5, 0) == 0);
      if (!keep_rdy) e.rdy = $urandom_range(1, 0) != 0;
    end
  endtask

  task automatic push_idle(input int n, input bit junk);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = base_e();
      if (junk) e.rdy = $urandom_range(1, 0) != 0;
      q.push_back(e);
    end
  endtask

  task automatic push_reset(input int n);
    ent_t e;
    cd_lvl    = 1'b0;
    err_lvl   = 1'b0;
    wmode_lvl = 2;
    for (int i = 0; i < n; i++) begin
      e     = base_e();
      e.rst = 1'b1;
      q.push_back(e);
    end
  endtask

  // One layer pass; abort_f/abort_k inject a reset at that read, to_f starves that RUN.
  task automatic build_pass(input bit junk, input int abort_f, input int abort_k, input int to_f);
    ent_t e;
    e    = base_e();
    e.st = 1'b1;
    q.push_back(e);
    err_lvl = 1'b0;
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < K2; k++) begin
        if (f == abort_f && k == abort_k) begin
          push_reset(1);
          push_idle(2, 1'b0);
          return;
        end
        e = base_e(); e.busy = 1; e.rd = 1; e.addr = f * K2 + k; e.wmode = 0;
        junkify(e, junk, 1'b0);
        q.push_back(e);
      end
      e = base_e(); e.busy = 1; e.wmode = 0;
      junkify(e, junk, 1'b0);
      q.push_back(e);
      wmode_lvl = 1;
      wf_lvl    = f;
      e = base_e(); e.busy = 1; e.clr = 1;
      junkify(e, junk, 1'b0);
      q.push_back(e);
      cd_lvl = 1'b0;
      if (f == to_f) begin
        for (int i = 0; i < TO; i++) begin
          e = base_e(); e.busy = 1; e.en = 1;
          junkify(e, junk, 1'b0);
          q.push_back(e);
        end
        err_lvl = 1'b1;
        push_idle(3, junk);
        return;
      end
      for (int i = 0; i < rr[f]; i++) begin
        if (i == rr[f] - 1) cd_lvl = 1'b1;
        e = base_e(); e.busy = 1; e.en = 1;
        junkify(e, junk, 1'b0);
        q.push_back(e);
      end
      for (int i = 0; i < hh[f]; i++) begin
        e = base_e(); e.busy = 1; e.vld = 1; e.filt = f; e.rdy = (i == hh[f] - 1);
        junkify(e, junk, 1'b1);
        q.push_back(e);
      end
    end
    e = base_e(); e.busy = 1; e.dn = 1;
    junkify(e, junk, 1'b0);
    q.push_back(e);
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      cur         = q.pop_front();
      reset       = cur.rst;
      start       = cur.st;
      conv_done   = cur.cd;
      ofmap_ready = cur.rdy;
      active      = 1'b1;
      cyc++;
    end
    @(posedge clk);
    #1;
    active = 1'b0;
  endtask

  // Single compare process, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (active) begin
      chk("busy", int'(busy), int'(cur.busy));
      chk("w_rd_en", int'(w_rd_en), int'(cur.rd));
      if (cur.rd || cur.rst) chk("w_rd_addr", int'(w_rd_addr), cur.addr);
      chk("conv_clear", int'(conv_clear), int'(cur.clr));
      chk("conv_en", int'(conv_en), int'(cur.en));
      chk("ofmap_valid", int'(ofmap_valid), int'(cur.vld));
      if (cur.vld || cur.rst) chk("ofmap_filter", int'(ofmap_filter), cur.filt);
      chk("done", int'(done), int'(cur.dn));
      chk("err", int'(err), int'(cur.er));
      if (cur.wmode != 0) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            chk("weights", int'(weights[r][c]),
                (cur.wmode == 2) ? 0 : cur.wf * K2 + r * K + c - 9);
          end
        end
      end
      if (done) done_cnt++;
      if (w_rd_en) addr_log.push_back(int'(w_rd_addr));
      if (conv_clear && !snap_taken) begin
        snap_taken = 1'b1;
        for (int c = 0; c < K; c++) snap[c] = int'(weights[0][c]);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    conv_done   = 1'b0;
    ofmap_ready = 1'b0;

    // Directed pass: conv_done 5 cycles into each RUN, immediate ready.
    push_reset(2);
    push_idle(2, 1'b0);
    rr[0] = 5; rr[1] = 5; hh[0] = 1; hh[1] = 1;
    build_pass(1'b0, -1, -1, -1);
    push_idle(2, 1'b0);
    run_queue();
    chk("lit_addr_count", addr_log.size(), 18);
    if (addr_log.size() == 18) begin
      chk("lit_addr_first", addr_log[0], 0);
      chk("lit_addr_f1", addr_log[9], 9);
      chk("lit_addr_last", addr_log[17], 17);
    end
    chk("lit_snap_w00", snap[0], -9);
    chk("lit_snap_w01", snap[1], -8);
    chk("lit_snap_w02", snap[2], -7);
    chk("lit_final_w00", int'(weights[0][0]), 0);
    chk("lit_final_w01", int'(weights[0][1]), 1);
    chk("lit_final_w22", int'(weights[2][2]), 8);
    chk("lit_done_count", done_cnt, 1);

    // Ready withheld for 10 cycles in OUT, start pulses while busy.
    rr[0] = 4; rr[1] = 6; hh[0] = 11; hh[1] = 1;
    build_pass(1'b1, -1, -1, -1);
    push_idle(2, 1'b1);

    // Reset during LOAD of filter 1 at k=4, then a fresh pass from address 0.
    rr[0] = 3; rr[1] = 2; hh[0] = 1; hh[1] = 2;
    build_pass(1'b1, 1, 4, -1);
    build_pass(1'b0, -1, -1, -1);
    push_idle(1, 1'b0);
    run_queue();

    // Randomized passes with random gaps, RUN lengths and handshake delays.
    for (int p = 0; p < 25; p++) begin
      for (int f = 0; f < NF; f++) begin
        rr[f] = $urandom_range(12, 1);
        hh[f] = $urandom_range(6, 1);
      end
      push_idle($urandom_range(3, 0), 1'b1);
      build_pass(1'b1, -1, -1, -1);
    end
    push_idle(2, 1'b0);
    run_queue();

`ifdef CONV_SCHED_TIMEOUT_EN
    // Starved RUN on filter 1 trips the watchdog; the next start clears err.
    rr[0] = 2; rr[1] = 2; hh[0] = 1; hh[1] = 1;
    build_pass(1'b1, -1, -1, 1);
    build_pass(1'b0, -1, -1, -1);
    push_idle(2, 1'b0);
    run_queue();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
